// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXTEND   = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_PAUSE    = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } simon_state_t;

  typedef logic [1:0] color_t;

  localparam logic [3:0] LED_ALL = 4'b1111;

  function automatic logic [3:0] onehot(input color_t c);
    onehot = 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence store: synchronous write, combinational read; contents are not reset.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  color_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output color_t            rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  color_t mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows a random colour sequence, plays it on one-hot LEDs,
// checks the player's presses and reports level plus sticky win/lose.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 32,
  parameter int ON_TICKS      = 5,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 30,
  parameter int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  input  logic [11:0]      rand_val,
  output logic             rand_en,
  input  logic             btn_valid,
  input  logic [1:0]       btn_color,
  output logic [3:0]       led,
  output logic [LEN_W-1:0] level,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAX_A   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_MAX = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  simon_state_t     state_r, state_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [LEN_W-1:0] pos_r, pos_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             last_s;
  logic             mem_we_s;
  color_t           rd_color_s;
  logic [3:0]       led_s;
  logic             rand_en_r, busy_r, win_r, lose_r;
  logic             unused_rand_s;

  assign unused_rand_s = ^rand_val[11:2];
  assign cnt_inc_s     = cnt_r + CNT_W'(1);
  assign last_s        = (pos_r == (len_r - LEN_W'(1)));

  simon_seq_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (len_r[ADDR_W-1:0]),
    .wdata (rand_val[1:0]),
    .raddr (pos_r[ADDR_W-1:0]),
    .rdata (rd_color_s)
  );

  // Next-state logic for the game FSM and its counters
  always_comb begin
    state_s  = state_r;
    len_s    = len_r;
    pos_s    = pos_r;
    cnt_s    = cnt_r;
    mem_we_s = 1'b0;
    case (state_r)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          len_s   = {LEN_W{1'b0}};
          pos_s   = {LEN_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_EXTEND;
        end else begin
          state_s = state_r;
        end
      end
      S_EXTEND: begin
        mem_we_s = 1'b1;
        len_s    = len_r + LEN_W'(1);
        pos_s    = {LEN_W{1'b0}};
        cnt_s    = {CNT_W{1'b0}};
        state_s  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick) begin
          if (cnt_inc_s == CNT_W'(ON_TICKS)) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_SHOW_OFF;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_SHOW_OFF: begin
        if (tick) begin
          if (cnt_inc_s == CNT_W'(OFF_TICKS)) begin
            cnt_s = {CNT_W{1'b0}};
            if (last_s) begin
              pos_s   = {LEN_W{1'b0}};
              state_s = S_WAIT_IN;
            end else begin
              pos_s   = pos_r + LEN_W'(1);
              state_s = S_SHOW_ON;
            end
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_WAIT_IN: begin
        // A press takes priority; a coincident tick is dropped
        if (btn_valid) begin
          if (btn_color == rd_color_s) begin
            cnt_s = {CNT_W{1'b0}};
            if (last_s) begin
              if (len_r == LEN_W'(MAX_LEN)) begin
                state_s = S_WIN;
              end else begin
                state_s = S_PAUSE;
              end
            end else begin
              pos_s = pos_r + LEN_W'(1);
            end
          end else begin
            state_s = S_LOSE;
          end
        end else if (tick) begin
          if (cnt_inc_s == CNT_W'(TIMEOUT_TICKS)) begin
            state_s = S_LOSE;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_PAUSE: begin
        if (tick) begin
          if (cnt_inc_s == CNT_W'(OFF_TICKS)) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_EXTEND;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      len_r     <= {LEN_W{1'b0}};
      pos_r     <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      rand_en_r <= 1'b0;
      busy_r    <= 1'b0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      pos_r     <= pos_s;
      cnt_r     <= cnt_s;
      rand_en_r <= (state_s == S_EXTEND);
      busy_r    <= !((state_s == S_IDLE) || (state_s == S_WIN) || (state_s == S_LOSE));
      win_r     <= (state_s == S_WIN);
      lose_r    <= (state_s == S_LOSE);
    end
  end

  // LED decode from registered state, so async reset blanks it at once
  always_comb begin
    case (state_r)
      S_SHOW_ON: led_s = onehot(rd_color_s);
      S_WIN:     led_s = LED_ALL;
      default:   led_s = 4'b0000;
    endcase
  end

  assign led     = led_s;
  assign rand_en = rand_en_r;
  assign level   = len_r;
  assign busy    = busy_r;
  assign win     = win_r;
  assign lose    = lose_r;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed self-checking bench for simon_sequencer (MAX_LEN=4, ON=2, OFF=1, TIMEOUT=30).
module tb_simon_sequencer;

  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             tick = 1'b0;
  logic [11:0]      rand_val;
  logic             rand_en;
  logic             btn_valid = 1'b0;
  logic [1:0]       btn_color = 2'd0;
  logic [3:0]       led;
  logic [LEN_W-1:0] level;
  logic             busy, win, lose;

  int checks = 0;
  int errors = 0;

  logic [11:0] pat [4];
  logic [1:0]  ridx = 2'd0;
  int          rand_cnt = 0;
  int          rand_dbl = 0;
  logic        rand_en_q = 1'b0;

  logic [3:0] cap_on0 [8];
  logic [3:0] cap_on1 [8];
  logic [3:0] cap_off [8];

  logic [1:0] cols [4];
  logic [3:0] leds [4];

  simon_sequencer #(
    .MAX_LEN(4), .ON_TICKS(2), .OFF_TICKS(1), .TIMEOUT_TICKS(30)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .rand_val(rand_val),
    .rand_en(rand_en), .btn_valid(btn_valid), .btn_color(btn_color),
    .led(led), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Pattern source model: advances on rand_en
  assign rand_val = pat[ridx];
  always @(posedge clk) begin
    if (rand_en) begin
      ridx     <= ridx + 2'd1;
      rand_cnt <= rand_cnt + 1;
    end
    if (rand_en && rand_en_q) rand_dbl <= rand_dbl + 1;
    rand_en_q <= rand_en;
  end

  task automatic tick_once();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    @(posedge clk); #1;
    btn_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic play_collect(input int n);
    for (int i = 0; i < n; i++) begin
      cap_on0[i] = led;
      tick_once();
      cap_on1[i] = led;
      tick_once();
      cap_off[i] = led;
      tick_once();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0000 || level !== 3'd0 || busy !== 1'b0 || win !== 1'b0 ||
        lose !== 1'b0 || rand_en !== 1'b0) begin
      errors++;
      $display("FAIL reset led=%b level=%0d busy=%b win=%b lose=%b rand_en=%b expected 0000/0/0/0/0/0",
               led, level, busy, win, lose, rand_en);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rand_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b rand_en=%b expected 0/0", busy, rand_en);
    end
  endtask

  task automatic test_first_round();
    do_start();
    checks++;
    if (rand_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL extend rand_en=%b busy=%b expected 1/1", rand_en, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (rand_en !== 1'b0 || level !== 3'd1 || led !== 4'b0010) begin
      errors++;
      $display("FAIL round1_show rand_en=%b level=%0d led=%b expected 0/1/0010", rand_en, level, led);
    end
    play_collect(1);
    checks++;
    if (cap_on0[0] !== 4'b0010 || cap_on1[0] !== 4'b0010 || cap_off[0] !== 4'b0000) begin
      errors++;
      $display("FAIL round1_play on=%b/%b off=%b expected 0010/0010/0000",
               cap_on0[0], cap_on1[0], cap_off[0]);
    end
    checks++;
    if (led !== 4'b0000 || busy !== 1'b1 || rand_cnt !== 1) begin
      errors++;
      $display("FAIL round1_wait led=%b busy=%b rand_cnt=%0d expected 0000/1/1", led, busy, rand_cnt);
    end
    press(2'd1);
  endtask

  task automatic test_rounds();
    for (int r = 2; r <= 4; r++) begin
      tick_once();
      checks++;
      if (level !== LEN_W'(r) || rand_cnt !== r || busy !== 1'b1) begin
        errors++;
        $display("FAIL round%0d_start level=%0d rand_cnt=%0d busy=%b expected %0d/%0d/1",
                 r, level, rand_cnt, busy, r, r);
      end
      play_collect(r);
      for (int i = 0; i < r; i++) begin
        checks++;
        if (cap_on0[i] !== leds[i] || cap_on1[i] !== leds[i] || cap_off[i] !== 4'b0000) begin
          errors++;
          $display("FAIL round%0d_step%0d on=%b/%b off=%b expected %b/%b/0000",
                   r, i, cap_on0[i], cap_on1[i], cap_off[i], leds[i], leds[i]);
        end
      end
      for (int i = 0; i < r; i++) press(cols[i]);
    end
  endtask

  task automatic test_win();
    checks++;
    if (win !== 1'b1 || led !== 4'b1111 || busy !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL win win=%b led=%b busy=%b lose=%b expected 1/1111/0/0", win, led, busy, lose);
    end
    repeat (3) tick_once();
    checks++;
    if (rand_cnt !== 4 || rand_dbl !== 0 || win !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL win_hold rand_cnt=%0d dbl=%0d win=%b level=%0d expected 4/0/1/4",
               rand_cnt, rand_dbl, win, level);
    end
  endtask

  task automatic test_restart_lose();
    do_start();
    checks++;
    if (win !== 1'b0 || rand_en !== 1'b1) begin
      errors++;
      $display("FAIL restart win=%b rand_en=%b expected 0/1", win, rand_en);
    end
    @(posedge clk); #1;
    checks++;
    if (level !== 3'd1 || led !== 4'b0010 || rand_cnt !== 5) begin
      errors++;
      $display("FAIL restart_show level=%0d led=%b rand_cnt=%0d expected 1/0010/5", level, led, rand_cnt);
    end
    play_collect(1);
    press(2'd1);
    tick_once();
    play_collect(2);
    checks++;
    if (cap_on0[0] !== 4'b0010 || cap_on0[1] !== 4'b0100) begin
      errors++;
      $display("FAIL lose_round2_play got %b,%b expected 0010,0100", cap_on0[0], cap_on0[1]);
    end
    press(2'd1);
    press(2'd0);
    checks++;
    if (lose !== 1'b1 || led !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_press lose=%b led=%b busy=%b expected 1/0000/0", lose, led, busy);
    end
    press(2'd2);
    tick_once();
    tick_once();
    checks++;
    if (lose !== 1'b1 || win !== 1'b0 || level !== 3'd2 || busy !== 1'b0 || rand_cnt !== 6) begin
      errors++;
      $display("FAIL lose_hold lose=%b win=%b level=%0d busy=%b rand_cnt=%0d expected 1/0/2/0/6",
               lose, win, level, busy, rand_cnt);
    end
  endtask

  task automatic test_timeout();
    do_start();
    @(posedge clk); #1;
    play_collect(1);
    checks++;
    if (cap_on0[0] !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_play got %b expected 1000", cap_on0[0]);
    end
    repeat (29) tick_once();
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_29 lose=%b busy=%b expected 0/1", lose, busy);
    end
    tick_once();
    checks++;
    if (lose !== 1'b1) begin
      errors++;
      $display("FAIL timeout_30 lose=%b expected 1", lose);
    end
  endtask

  task automatic test_press_resets_timeout();
    do_start();
    @(posedge clk); #1;
    play_collect(1);
    press(2'd0);
    // tick held across PAUSE and EXTEND; the EXTEND one must be ignored
    tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    play_collect(2);
    checks++;
    if (cap_on0[0] !== 4'b0001 || cap_on1[0] !== 4'b0001 || cap_on0[1] !== 4'b0010 ||
        rand_cnt !== 9) begin
      errors++;
      $display("FAIL extend_tick on=%b/%b next=%b rand_cnt=%0d expected 0001/0001/0010/9",
               cap_on0[0], cap_on1[0], cap_on0[1], rand_cnt);
    end
    repeat (28) tick_once();
    btn_valid = 1'b1;
    btn_color = 2'd0;
    tick = 1'b1;
    @(posedge clk); #1;
    btn_valid = 1'b0;
    tick = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL press_tick29 lose=%b busy=%b expected 0/1", lose, busy);
    end
    repeat (29) tick_once();
    checks++;
    if (lose !== 1'b0) begin
      errors++;
      $display("FAIL after_press_29 lose=%b expected 0", lose);
    end
    tick_once();
    checks++;
    if (lose !== 1'b1) begin
      errors++;
      $display("FAIL after_press_30 lose=%b expected 1", lose);
    end
  endtask

  task automatic test_rst_mid();
    do_start();
    @(posedge clk); #1;
    tick_once();
    checks++;
    if (led !== 4'b0100) begin
      errors++;
      $display("FAIL pre_rst led=%b expected 0100", led);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst led=%b level=%0d busy=%b expected 0000/0/0", led, level, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_start();
    @(posedge clk); #1;
    checks++;
    if (level !== 3'd1 || led !== 4'b1000 || rand_cnt !== 11 || lose !== 1'b0) begin
      errors++;
      $display("FAIL post_rst level=%0d led=%b rand_cnt=%0d lose=%b expected 1/1000/11/0",
               level, led, rand_cnt, lose);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pat[0] = 12'h001; pat[1] = 12'h0A2; pat[2] = 12'h3F3; pat[3] = 12'h100;
    cols[0] = 2'd1; cols[1] = 2'd2; cols[2] = 2'd3; cols[3] = 2'd0;
    leds[0] = 4'b0010; leds[1] = 4'b0100; leds[2] = 4'b1000; leds[3] = 4'b0001;
    test_reset();
    test_first_round();
    test_rounds();
    test_win();
    test_restart_lose();
    test_timeout();
    test_press_resets_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
Game controller for the Simon Says project. It pulls one colour per round from the pseudo-random pattern source by pulsing that source's advance enable, and stores the growing sequence in a local buffer. Each round it plays the sequence on four one-hot LEDs, then checks the player's button presses against it. It reports the current level and a sticky win/lose result to the display and audio logic.

Parameters:
MAX_LEN, 32, longest sequence; reaching it and entering it correctly is a win
ON_TICKS, 5, tick pulses an LED stays lit during playback
OFF_TICKS, 2, tick pulses of dark gap after each playback step and before each new round
TIMEOUT_TICKS, 30, tick pulses allowed between player presses before a loss
LEN_W, $clog2(MAX_LEN+1), width of level/length counters

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle pulse; begins a new game
tick  input  1  single-cycle timebase strobe (e.g. 10 Hz)
rand_val  input  12  current pattern-source word; colour = rand_val[1:0]
rand_en  output  1  advance strobe to the pattern source
btn_valid  input  1  single-cycle pulse, debounced player press
btn_color  input  2  colour of the press, qualified by btn_valid
led  output  4  one-hot playback LED, bit n = colour n
level  output  LEN_W  current sequence length
busy  output  1  high in any state except IDLE/WIN/LOSE
win  output  1  sticky win flag
lose  output  1  sticky lose flag

Behaviour:
- Reset (async, any state): state=IDLE, len=0, pos=0, tick_cnt=0, led=0, rand_en=0, win=0, lose=0. Buffer contents are don't-care.
- States: IDLE, EXTEND, SHOW_ON, SHOW_OFF, WAIT_IN, PAUSE, WIN, LOSE.
- IDLE/WIN/LOSE + start: clear len, pos, tick_cnt, win and lose; go to EXTEND next cycle. start is ignored in every other state.
- EXTEND (exactly 1 cycle):
  - rand_en=1.
  - buf[len] <= rand_val[1:0], sampled in the same cycle rand_en is high, i.e. the value before the source advances.
  - len <= len+1; pos <= 0; tick_cnt <= 0; go to SHOW_ON.
- rand_en is high only in EXTEND: one pulse per round, never two in consecutive cycles.
- SHOW_ON:
  - led = onehot(buf[pos]).
  - Each tick increments tick_cnt. On the tick making tick_cnt==ON_TICKS: go to SHOW_OFF, tick_cnt <= 0.
- SHOW_OFF:
  - led = 0.
  - On the OFF_TICKS-th tick: if pos==len-1, go to WAIT_IN with pos <= 0. Otherwise pos++ and go to SHOW_ON. tick_cnt <= 0 in both cases.
- WAIT_IN:
  - led = 0.
  - btn_valid with btn_color==buf[pos]:
    - pos==len-1 and len==MAX_LEN: go to WIN.
    - pos==len-1 and len<MAX_LEN: go to PAUSE.
    - Otherwise pos++.
    - tick_cnt <= 0 in all three cases.
  - btn_valid with mismatch: go to LOSE.
  - A tick with no btn_valid increments tick_cnt; reaching TIMEOUT_TICKS goes to LOSE.
  - btn_valid and tick in the same cycle: the press is processed and the tick is discarded.
- PAUSE: led=0; after OFF_TICKS ticks, go to EXTEND (tick_cnt <= 0). btn_valid is ignored.
- btn_valid outside WAIT_IN is ignored.
- WIN: win=1, led=4'b1111. LOSE: lose=1, led=0. Both hold until start or rst.
- level = len, updated the cycle after EXTEND; busy is a decode of the state.
- All outputs are registered or decoded from registered state only: no combinational path from inputs to outputs.
- Widths:
  - pos and len are LEN_W bits; buffer depth is MAX_LEN.
  - len never exceeds MAX_LEN, because the WIN check precedes EXTEND.
  - tick_cnt is sized for max(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS).
- Boundary conditions:
  - MAX_LEN=1: one EXTEND, one playback step, one press gives WIN.
  - A tick during EXTEND is ignored.
  - rst mid-playback: led drops to 0 immediately (async).

Decomposition:
- Package simon_pkg holds:
  - state enum simon_state_t;
  - typedef logic [1:0] color_t;
  - function onehot(color_t) returning logic [3:0];
  - LED_ALL = 4'b1111.
- One sub-module, simon_seq_mem: MAX_LEN x 2-bit register file with synchronous write (we, waddr, wdata) and combinational read (raddr).

Test Plan:
- Bench pattern-source model returns 0x001, 0x0A2, 0x3F3, 0x100 (colours 1,2,3,0) and advances on rand_en. start, then ON_TICKS=2 and OFF_TICKS=1 -> rand_en pulses once; level=1; led=4'b0010 for exactly 2 ticks, then 0 for 1 tick; busy=1.
- Correct presses each round -> round 2 plays 0010, 0100; round 3 plays 0010, 0100, 1000; exactly one rand_en per round; level increments 1,2,3.
- Round 2, second press btn_color=0 (expected 2) -> lose=1 the next cycle, led=0, busy=0; later presses have no effect.
- WAIT_IN with no press for TIMEOUT_TICKS=30 ticks -> lose asserts on the 30th tick. A press on tick 29 instead resets the count, and there is no loss.
- MAX_LEN=4, all correct -> win=1 and led=4'b1111 after the 4th press of round 4, no fifth rand_en. start then gives win=0, level=1 and a new rand_en.
- rst asserted mid-SHOW_ON -> led=0, level=0 and state IDLE immediately. start after release begins a clean game at level 1.
